// File: rtl/acc_frame_feeder_if.sv
// acc_frame_feeder_if: stream input, accumulator pins and frame-sum result port of acc_frame_feeder.
// master = surrounding system (source, accumulator, sink); slave = the feeder itself.
interface acc_frame_feeder_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              acc_enable;
  logic [DATA_W-1:0] acc_data;
  logic              acc_clear;
  logic [DATA_W-1:0] acc_sum;
  logic              sum_valid;
  logic              sum_ready;
  logic [DATA_W-1:0] sum_data;
  logic              sum_ovf;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output in_valid, in_data, in_last, acc_sum, sum_ready,
    input  in_ready, acc_enable, acc_data, acc_clear, sum_valid, sum_data, sum_ovf, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, acc_sum, sum_ready,
    output in_ready, acc_enable, acc_data, acc_clear, sum_valid, sum_data, sum_ovf, frame_cnt
  );
endinterface

// File: rtl/acc_frame_feeder.sv
// acc_frame_feeder: buffers a framed word stream, drives the accumulator from zero per frame, reports each sum.
// Define ACC_FEEDER_OVF_EN to build the carry-tracking shadow sum behind sum_ovf; otherwise sum_ovf is 0.
module acc_frame_feeder #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  acc_frame_feeder_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]        r_state;
  logic [DATA_W:0]   r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              r_accEnable;
  logic [DATA_W-1:0] r_accData;
  logic              r_accClear;
  logic              r_sumValid;
  logic [DATA_W-1:0] r_sumData;
  logic [CNT_W-1:0]  r_frameCnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_headData;
  logic              w_headLast;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = bus.in_valid && bus.in_ready;
  assign w_pop      = (r_state == S_RUN) && !w_empty;
  assign w_headData = r_fifoMem[r_rdPtr][DATA_W-1:0];
  assign w_headLast = r_fifoMem[r_rdPtr][DATA_W];

  assign bus.in_ready   = !w_full && !reset;
  assign bus.acc_enable = r_accEnable;
  assign bus.acc_data   = r_accData;
  assign bus.acc_clear  = r_accClear;
  assign bus.sum_valid  = r_sumValid;
  assign bus.sum_data   = r_sumData;
  assign bus.frame_cnt  = r_frameCnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= {bus.in_last, bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The accumulator sees each popped word one cycle after the pop; bubbles drive zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_accEnable <= 1'b0;
      r_accData   <= '0;
      r_accClear  <= 1'b0;
      r_sumValid  <= 1'b0;
      r_sumData   <= '0;
      r_frameCnt  <= '0;
    end else begin
      r_accEnable <= w_pop;
      r_accData   <= w_pop ? w_headData : '0;
      r_accClear  <= (r_state == S_CLEAR);
      case (r_state)
        S_CLEAR: r_state <= S_RUN;
        S_RUN: begin
          if (w_pop && w_headLast) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: r_state <= S_CAPT;
        S_CAPT: begin
          r_sumData  <= bus.acc_sum;
          r_sumValid <= 1'b1;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.sum_ready) begin
            r_sumValid <= 1'b0;
            r_frameCnt <= r_frameCnt + 1'b1;
            r_state    <= S_CLEAR;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

`ifdef ACC_FEEDER_OVF_EN
  logic [DATA_W:0] r_shadowSum;
  logic [DATA_W:0] w_shadowAdd;
  logic            r_sumOvf;

  assign w_shadowAdd = {1'b0, r_shadowSum[DATA_W-1:0]} + {1'b0, w_headData};

  // The shadow's top bit is a sticky carry flag for the current frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadowSum <= '0;
      r_sumOvf    <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_shadowSum <= '0;
      end else if (w_pop) begin
        r_shadowSum <= {r_shadowSum[DATA_W] | w_shadowAdd[DATA_W], w_shadowAdd[DATA_W-1:0]};
      end
      if (r_state == S_CAPT) begin
        r_sumOvf <= r_shadowSum[DATA_W];
      end
    end
  end

  assign bus.sum_ovf = r_sumOvf;
`else
  assign bus.sum_ovf = 1'b0;
`endif
endmodule
